// File: rtl/alpha_fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alpha_fetch_pkg
// Description : Shared widths, constants and the fetch-entry record used by
//               the instruction fetch buffer and its FIFO.
// Contents    : INST_W, PC_W, NOP_INST, METAL_BASE, fetch_entry
// Revision    : 1.0 - initial release
// ============================================================================
package alpha_fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 64;

    // BIS r31,r31,r31 - the decode stage treats it as a bubble.
    localparam logic [INST_W-1:0] NOP_INST   = 32'h47ff041f;
    // Lowest address served by the Metal microcode memory.
    localparam logic [PC_W-1:0]   METAL_BASE = 64'hffff_ffff_ffff_0000;

    // One buffered instruction together with where it came from.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              metal;
    } fetch_entry;

endpackage : alpha_fetch_pkg
`default_nettype wire

// File: rtl/alpha_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : alpha_fetch_buffer_if
// Description : Bus bundle between the fetch buffer, the two instruction
//               sources (icache, Metal memory) and the Ebox decode stage.
// Ports       : redirect_valid/redirect_pc  - flush and new fetch PC
//               icache_data/icache_stall    - instruction cache return
//               metal_data/metal_stall      - Metal memory return
//               ebox_stall                  - decode back-pressure
//               fetch_pc, *_read_en         - fetch address and selects
//               inst, inst_pc, inst_valid,
//               inst_metal                  - head instruction to decode
//               count                       - FIFO occupancy (debug)
// Modports    : master - the fetch buffer; slave - its environment
// Revision    : 1.0 - initial release
// ============================================================================
interface alpha_fetch_buffer_if #(
    parameter int DEPTH = 4
);
    import alpha_fetch_pkg::*;

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                redirect_valid;
    logic [PC_W-1:0]     redirect_pc;
    logic [INST_W-1:0]   icache_data;
    logic                icache_stall;
    logic [INST_W-1:0]   metal_data;
    logic                metal_stall;
    logic                ebox_stall;

    logic [PC_W-1:0]     fetch_pc;
    logic                icache_read_en;
    logic                metal_read_en;
    logic [INST_W-1:0]   inst;
    logic [PC_W-1:0]     inst_pc;
    logic                inst_valid;
    logic                inst_metal;
    logic [c_cnt_w-1:0]  count;

    modport master (
        input  redirect_valid, redirect_pc, icache_data, icache_stall,
               metal_data, metal_stall, ebox_stall,
        output fetch_pc, icache_read_en, metal_read_en, inst, inst_pc,
               inst_valid, inst_metal, count
    );

    modport slave (
        output redirect_valid, redirect_pc, icache_data, icache_stall,
               metal_data, metal_stall, ebox_stall,
        input  fetch_pc, icache_read_en, metal_read_en, inst, inst_pc,
               inst_valid, inst_metal, count
    );

endinterface : alpha_fetch_buffer_if
`default_nettype wire

// File: rtl/alpha_fetch_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch_entry records with a registered
//               storage array. Flush empties it in one edge and overrides
//               any push/pop in the same cycle.
// Ports       : clk, rst                    - clock, sync active-high reset
//               i_push/i_data               - enqueue (ignored when full)
//               i_pop                       - dequeue (ignored when empty)
//               i_flush                     - discard all entries
//               o_head                      - entry at the read pointer
//               o_full/o_empty/o_count      - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import alpha_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire fetch_entry                 i_data,
    input  wire logic                       i_pop,
    input  wire logic                       i_flush,
    output fetch_entry                      o_head,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(DEPTH):0]          o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    fetch_entry          r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_push;
    logic                w_pop;

    always_comb begin
        o_full  = (r_count == c_cnt_w'(DEPTH));
        o_empty = (r_count == '0);
        w_push  = i_push && !o_full;
        w_pop   = i_pop  && !o_empty;
        o_head  = r_mem[r_rd_ptr];
        o_count = r_count;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // Storage needs no reset: every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/alpha_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : alpha_fetch_buffer
// Description : Instruction fetch stage ahead of Ebox decode. Owns the fetch
//               PC, steers reads to the icache or Metal memory by address,
//               buffers returned instructions and flushes on redirect.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous active-high reset
//               bus    - alpha_fetch_buffer_if.master (sources, redirect,
//                        decode handshake, debug count)
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_fetch_buffer #(
    parameter int          DEPTH      = 4,
    parameter logic [63:0] PC_RESET   = 64'h0,
    parameter logic [63:0] METAL_BASE = alpha_fetch_pkg::METAL_BASE,
    parameter logic [31:0] NOP_INST   = alpha_fetch_pkg::NOP_INST
) (
    input  wire logic               clk,
    input  wire logic               reset,
    alpha_fetch_buffer_if.master    bus
);
    import alpha_fetch_pkg::*;

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]     r_fetch_pc;

    logic                w_metal;
    logic                w_fetch_en;
    logic                w_src_stall;
    logic [INST_W-1:0]   w_src_data;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_cnt_w-1:0]  w_count;
    fetch_entry          w_push_entry;
    fetch_entry          w_head;
    logic [1:0]          w_unused_pc_lsb;

    // Redirect targets are word aligned; the low bits are dropped.
    assign w_unused_pc_lsb = bus.redirect_pc[1:0];

    // Fetch enable deliberately ignores ebox_stall: a full FIFO blocks fetch
    // even if the head leaves this cycle, keeping decode back-pressure off
    // the read-enable timing path.
    always_comb begin
        w_metal      = (r_fetch_pc >= METAL_BASE);
        w_fetch_en   = !w_full && !bus.redirect_valid;
        w_src_stall  = w_metal ? bus.metal_stall : bus.icache_stall;
        w_src_data   = w_metal ? bus.metal_data  : bus.icache_data;
        w_push       = w_fetch_en && !w_src_stall;
        w_pop        = !w_empty && !bus.ebox_stall;
        w_push_entry = '{pc: r_fetch_pc, inst: w_src_data, metal: w_metal};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= PC_RESET;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 64'd4;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        bus.fetch_pc       = r_fetch_pc;
        bus.icache_read_en = w_fetch_en && !w_metal;
        bus.metal_read_en  = w_fetch_en &&  w_metal;
        bus.inst_valid     = !w_empty;
        bus.inst           = w_empty ? NOP_INST : w_head.inst;
        bus.inst_pc        = w_empty ? '0       : w_head.pc;
        bus.inst_metal     = !w_empty && w_head.metal;
        bus.count          = w_count;
    end

endmodule : alpha_fetch_buffer
`default_nettype wire

// File: tb/tb_alpha_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alpha_fetch_buffer
// Description : Self-checking bench for alpha_fetch_buffer. Directed
//               scenarios followed by random traffic, all compared against
//               a queue-based reference model of the fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alpha_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] PC_RESET = 64'h0;
    localparam logic [63:0] MB       = 64'hffff_ffff_ffff_0000;
    localparam logic [31:0] NOP      = 32'h47ff041f;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alpha_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    alpha_fetch_buffer #(
        .DEPTH      (DEPTH),
        .PC_RESET   (PC_RESET),
        .METAL_BASE (MB),
        .NOP_INST   (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        metal;
    } m_entry_t;

    m_entry_t    m_q[$];
    logic [63:0] m_pc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One clock: drive inputs after the falling edge, compare outputs against
    // the model, then advance the model on the rising edge.
    task automatic step(input logic rst_i, input logic rv,
                        input logic [63:0] rpc, input logic ics,
                        input logic ms, input logic es);
        logic     full;
        logic     metal;
        logic     en;
        logic     src_stall;
        logic [31:0] src_data;
        m_entry_t e;
        @(negedge clk);
        reset              = rst_i;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.icache_stall   = ics;
        bus.metal_stall    = ms;
        bus.ebox_stall     = es;
        bus.icache_data    = $urandom;
        bus.metal_data     = $urandom;
        #1;
        full  = (m_q.size() == DEPTH);
        metal = (m_pc >= MB);
        en    = !full && !rv;
        check_val("fetch_pc",       bus.fetch_pc,       m_pc);
        check_val("icache_read_en", 64'(bus.icache_read_en), 64'(en && !metal));
        check_val("metal_read_en",  64'(bus.metal_read_en),  64'(en && metal));
        check_val("count",          64'(bus.count),     64'(m_q.size()));
        check_val("inst_valid",     64'(bus.inst_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("inst",       64'(bus.inst),       64'(m_q[0].inst));
            check_val("inst_pc",    bus.inst_pc,         m_q[0].pc);
            check_val("inst_metal", 64'(bus.inst_metal), 64'(m_q[0].metal));
        end else begin
            check_val("inst_nop",   64'(bus.inst),       64'(NOP));
            check_val("inst_pc0",   bus.inst_pc,         64'h0);
            check_val("inst_metal0", 64'(bus.inst_metal), 64'h0);
        end
        src_stall = metal ? ms : ics;
        src_data  = metal ? bus.metal_data : bus.icache_data;
        @(posedge clk);
        if (rst_i) begin
            m_q.delete();
            m_pc = PC_RESET;
        end else if (rv) begin
            m_q.delete();
            m_pc = rpc & ~64'h3;
        end else begin
            if (m_q.size() != 0 && !es) void'(m_q.pop_front());
            if (!full && !src_stall) begin
                e.pc = m_pc; e.inst = src_data; e.metal = metal;
                m_q.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic run(input int n, input logic ics, input logic es);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0, ics, 1'b0, es);
    endtask

    initial begin
        logic [63:0] tgt;
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.icache_data    = '0;
        bus.icache_stall   = 1'b0;
        bus.metal_data     = '0;
        bus.metal_stall    = 1'b0;
        bus.ebox_stall     = 1'b0;
        m_pc = PC_RESET;
        @(posedge clk);

        // Reset state, then free-running sequential fetch.
        step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        run(8, 1'b0, 1'b0);

        // Decode back-pressure fills the FIFO, then drains in order.
        run(6, 1'b0, 1'b1);
        run(6, 1'b0, 1'b0);

        // Icache stall drains the FIFO to empty; fetch resumes at held PC.
        run(3, 1'b1, 1'b0);
        run(3, 1'b0, 1'b0);

        // Redirect into Metal space with entries buffered.
        run(2, 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'hffff_ffff_ffff_0013, 1'b0, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0);

        // Sequential fetch crossing into Metal space.
        step(1'b0, 1'b1, 64'hffff_ffff_fffe_fffc, 1'b0, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 64'hffff_ffff_ffff_fff8, 1'b0, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);

        // Back-to-back redirects: the last one wins.
        step(1'b0, 1'b1, 64'h0000_0000_0000_1000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 64'h0000_0000_0000_2002, 1'b0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);

        // Reset wins over a simultaneous redirect with a full FIFO.
        run(6, 1'b0, 1'b1);
        step(1'b1, 1'b1, 64'h0000_0000_0000_4440, 1'b0, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 2))
                0:       tgt = MB - 64'($urandom_range(0, 8) * 4) + 64'($urandom_range(0, 3));
                1:       tgt = {$urandom, $urandom};
                default: tgt = 64'($urandom_range(0, 4096));
            endcase
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 19) == 0,
                 tgt,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alpha_fetch_buffer
`default_nettype wire

// File: doc/alpha_fetch_buffer.md
Name: alpha_fetch_buffer

Overview:
- Instruction fetch stage sitting directly upstream of the Ebox decode stage.
- Owns the fetch PC and steers reads to either the normal instruction cache or the Metal microcode memory. Metal is selected when pc >= METAL_BASE.
- Buffers fetched instructions in a small FIFO so a source stall and an Ebox stall are decoupled.
- Presents one instruction per cycle with a valid flag, and flushes and redirects on taken branches, jumps and Metal enter/exit.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PC_RESET, 64'h0: fetch PC after reset.
- METAL_BASE, 64'hffffffffffff0000: lowest address served by Metal memory.
- NOP_INST, 32'h47ff041f: instruction driven when the FIFO is empty (BIS r31,r31,r31).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  flush the buffer and load a new fetch PC.
- redirect_pc  in  64  target PC; bits [1:0] are ignored and forced to 0.
- icache_data  in  32  instruction-cache read data for fetch_pc.
- icache_stall  in  1  cache data not valid this cycle.
- metal_data  in  32  Metal memory read data for fetch_pc.
- metal_stall  in  1  Metal data not valid this cycle.
- ebox_stall  in  1  Ebox cannot accept the head instruction this cycle.
- fetch_pc  out  64  current fetch address, driven to both memories.
- icache_read_en  out  1  fetch enabled and fetch_pc < METAL_BASE.
- metal_read_en  out  1  fetch enabled and fetch_pc >= METAL_BASE.
- inst  out  32  head instruction, or NOP_INST when the FIFO is empty.
- inst_pc  out  64  PC of the head instruction, or 0 when the FIFO is empty.
- inst_valid  out  1  FIFO not empty.
- inst_metal  out  1  head instruction was fetched from Metal memory.
- count  out  log2(DEPTH)+1  occupancy (debug).

Behaviour:
- Reset values:
  - fetch_pc = PC_RESET; count = 0.
  - inst_valid = 0, inst = NOP_INST, inst_pc = 0, inst_metal = 0.
  - Read enables reflect PC_RESET range with fetch enabled.
- Fetch enable: fetch_en = !full && !redirect_valid.
  - The enable does not depend on ebox_stall; there is no combinational path from ebox_stall to the read enables.
- Source selection:
  - metal = (fetch_pc >= METAL_BASE), an unsigned 64-bit compare.
  - src_stall and src_data come from the selected source; the unselected source's stall and data are ignored.
- Enqueue: when fetch_en && !src_stall, at the clock edge:
  - push {fetch_pc, src_data, metal};
  - fetch_pc <= fetch_pc + 4 (64-bit, wraps modulo 2^64).
  - The entry is visible at the head the following cycle: fetch-to-issue latency is 1 cycle.
- Source stall: nothing is pushed and fetch_pc holds.
- Full (count == DEPTH): nothing is fetched and fetch_pc holds, even if the head dequeues in the same cycle. The refill happens the next cycle.
- Dequeue: when inst_valid && !ebox_stall, the head is popped at the edge.
- Empty: inst_valid = 0 and the outputs show the NOP/0 defaults. The Ebox treats the NOP as a bubble.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both pointers advance.
- Redirect, at the edge:
  - the FIFO is flushed (count = 0, pointers = 0);
  - fetch_pc <= {redirect_pc[63:2], 2'b00};
  - any in-flight source data that cycle is discarded, even if a pop occurs the same cycle.
  - Next cycle inst_valid = 0; the first redirected instruction appears at the earliest 2 cycles after redirect_valid is asserted.
- Back-to-back redirects: the last one wins.
- Reset has priority over redirect. Reset mid-operation flushes the FIFO and restores PC_RESET.
- Range crossing: the PC increments across METAL_BASE without special handling; each entry records its own metal bit.

Decomposition:
- Package alpha_fetch_pkg holds INST_W = 32, PC_W = 64, the NOP_INST constant, the METAL_BASE constant, and the fetch_entry struct {pc, inst, metal}.
- One sub-module, fetch_fifo: a synchronous FIFO of fetch_entry, with push/pop/flush, full/empty and count, and a registered storage array.
- The top level contains the PC register, source select and control logic.

Test Plan:
- Reset, then no stalls and ebox_stall = 0 -> fetch_pc = 0, 4, 8, …; inst_valid rises 1 cycle after reset deasserts; inst_pc = 0, 4, 8 in consecutive cycles.
- ebox_stall = 1 held for 6 cycles from a running state -> count climbs to 4 and stays there; fetch_pc holds at head_pc + 16; on release, heads issue in order with no loss or duplication.
- icache_stall = 1 for 3 cycles -> fetch_pc holds; FIFO drains to empty; inst = 32'h47ff041f with inst_valid = 0; fetch resumes at the held PC.
- redirect_valid with redirect_pc = 64'hffffffffffff0013 while FIFO has 3 entries -> next cycle count = 0 and fetch_pc = 64'hffffffffffff0010; metal_read_en = 1; icache_read_en = 0; the first head has inst_metal = 1 and inst = metal_data.
- PC crossing: redirect to 64'hfffffffffffefffc -> first entry has inst_metal = 0, second entry pc = 64'hffffffffffff0000 with inst_metal = 1.
- reset and redirect_valid asserted in the same cycle with a full FIFO -> fetch_pc = PC_RESET and count = 0; redirect_pc is ignored.
